multiplier_nbit_seq: RTL and testbench
======================================

# multiplier_nbit_seq

Parametrised sequential signed multiplier using add-shift with final-step subtract correction: it multiplies a WIDTH-bit two's-complement multiplicand, taken from switch input S, by a WIDTH-bit multiplier held in register B. The 2·WIDTH-bit product is left in A:B, with X as the sign extension bit. It is the generalised successor of the fixed 8-bit lab multiplier. New behaviour over that design:
- WIDTH parameter
- multiplicand latched at start
- explicit Busy/Done handshake
- protected loads while busy
- chained multiplications

Hex display decoding sits outside this block.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- Clk  in  1  the only clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high; overrides every other input.
- Run  in  1  level; start request, sampled in IDLE; must drop to re-arm after completion.
- ClearA_LoadB  in  1  level; clears A and X and loads B from S; honoured only in IDLE and DONE.
- S  in  WIDTH  switch input; supplies the B load value and the multiplicand.
- Aval  out  WIDTH  register A (product upper half).
- Bval  out  WIDTH  register B (multiplier; product lower half at completion).
- X  out  1  sign-extension bit of A.
- Busy  out  1  high in ADD and SHIFT states.
- Done  out  1  high in DONE state.

## Operation
- Registers:
  - A (WIDTH bits), B (WIDTH bits) and X (1 bit).
  - M (WIDTH bits), the internal multiplicand latch.
  - cnt, a bit counter of width $clog2(WIDTH).
- State machine: IDLE, ADD, SHIFT, DONE.
- IDLE:
  - ClearA_LoadB=1: A<=0, X<=0, B<=S; stay in IDLE. This takes priority over Run.
  - Else if Run=1: A<=0, X<=0, M<=S, cnt<=0; go to ADD. B is kept, so the previous low half becomes the new multiplier (chaining).
- ADD:
  - If B[0]=1: {X,A} <= sext(A) + sext(M) when cnt<WIDTH-1, and sext(A) - sext(M) when cnt==WIDTH-1.
  - All arithmetic is (WIDTH+1)-bit two's complement; carry out of bit WIDTH is discarded.
  - If B[0]=0: A and X are unchanged.
  - Next state: SHIFT.
- SHIFT:
  - Arithmetic right shift of {X,A,B} by one: A <= {X, A[WIDTH-1:1]}, B <= {A[0], B[WIDTH-1:1]}; X is unchanged.
  - If cnt==WIDTH-1: go to DONE. Otherwise cnt<=cnt+1 and go to ADD.
- DONE:
  - {A,B} holds the signed product M×B_initial; X equals A[WIDTH-1].
  - ClearA_LoadB=1 performs the IDLE load but stays in DONE.
  - Run=0 moves to IDLE.
- Inputs ignored while Busy: ClearA_LoadB, Run, and changes on S. M guarantees S changes mid-operation have no effect.
- Reset, in any state including mid-operation: A, B, X, M and cnt all <= 0; state <= IDLE.

## Timing
- Reset values: Aval=0, Bval=0, X=0, Busy=0, Done=0.
- Edge numbering: edge 0 is the edge on which Run=1 is sampled in IDLE.
- Busy rises after edge 0.
- There are 2·WIDTH edges of ADD/SHIFT. Done rises after edge 2·WIDTH, and Busy falls on that same edge.
- WIDTH=8: 16 busy cycles; Done is visible 17 edges after start.
- A held Run produces exactly one multiplication. The next start requires Run=0 in DONE (1 edge to IDLE), then Run=1.
- ClearA_LoadB takes effect on the next edge (1-cycle latency). Outputs are registers with no combinational input-to-output paths.
- Simultaneous Reset with any input: Reset wins.
- Simultaneous ClearA_LoadB and Run in IDLE: the load wins, and there is no start on that edge.

## Test plan
- WIDTH=8:
  - Load B=0x03, start with S=0x07 → after 17 edges Done=1, A=0x00, B=0x15, X=0.
  - B=0xFF, S=0xFF (−1×−1) → A=0x00, B=0x01, X=0.
  - B=0x7F, S=0x80 (−128×127) → A=0xC0, B=0x80, X=1.
  - B=0x80, S=0x80 (−128×−128) → A=0x40, B=0x00, X=0.
  - Chaining: B=0x02, S=0x03 → B=0x06. Drop Run, restart with S=0x03 → A=0x00, B=0x12.
  - Robustness during one run:
    - Toggle S and pulse ClearA_LoadB while Busy → result unaffected.
    - Assert Reset at edge 5 → next cycle A=B=X=0, Busy=0, Done=0, state IDLE.
- WIDTH=4:
  - B=0x9 (−7), S=0x5 → {A,B}=0xDD (−35), X=1; Done after 9 edges.
  - Hold Run high → no second start until Run low for ≥1 edge.

Source files
------------

// File: rtl/multiplier_nbit_seq.sv
// Sequential signed add-shift multiplier: M (latched from S) times B, product left in A:B.
// The last partial product is subtracted so that B is treated as a two's-complement multiplier.
module multiplier_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic             r_x;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_a_ext;
  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_sum;

  assign w_a_ext = {r_a[WIDTH-1], r_a};
  assign w_m_ext = {r_m[WIDTH-1], r_m};
  assign w_sum   = (r_cnt == LAST) ? (w_a_ext - w_m_ext) : (w_a_ext + w_m_ext);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: w_next gets a default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!ClearA_LoadB && Run) w_next = ADD;
      ADD:     w_next = SHIFT;
      SHIFT:   if (r_cnt == LAST) w_next = DONE;
               else               w_next = ADD;
      DONE:    if (!ClearA_LoadB && !Run) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_m   <= '0;
      r_x   <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ClearA_LoadB) begin
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= S;
          end else if (Run) begin
            // B is left alone so the previous low half chains in as the new multiplier.
            r_a   <= '0;
            r_x   <= 1'b0;
            r_m   <= S;
            r_cnt <= '0;
          end
        end
        ADD: begin
          if (r_b[0]) {r_x, r_a} <= w_sum;
        end
        SHIFT: begin
          r_a <= {r_x, r_a[WIDTH-1:1]};
          r_b <= {r_a[0], r_b[WIDTH-1:1]};
          if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          if (ClearA_LoadB) begin
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= S;
          end
        end
        default: ;
      endcase
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;
  assign Busy = (r_state == ADD) || (r_state == SHIFT);
  assign Done = (r_state == DONE);

endmodule

// File: tb/tb_multiplier_nbit_seq.sv
// Directed bench for multiplier_nbit_seq at WIDTH=8 and WIDTH=4 with hand-computed products.
module tb_multiplier_nbit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       run8, clr8, run4, clr4;
  logic [7:0] s8, a8, b8;
  logic [3:0] s4, a4, b4;
  logic       x8, busy8, done8, x4, busy4, done4;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  multiplier_nbit_seq #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Reset(rst), .Run(run8), .ClearA_LoadB(clr8), .S(s8),
    .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
  );

  multiplier_nbit_seq #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Reset(rst), .Run(run4), .ClearA_LoadB(clr4), .S(s4),
    .Aval(a4), .Bval(b4), .X(x4), .Busy(busy4), .Done(done4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input bit w4, input logic [7:0] v);
    @(negedge clk);
    if (w4) begin s4 = v[3:0]; clr4 = 1'b1; end
    else    begin s8 = v;      clr8 = 1'b1; end
    @(negedge clk);
    clr4 = 1'b0;
    clr8 = 1'b0;
  endtask

  // Raises Run with multiplicand s and counts negedges until Done; disturb scrambles S and pulses the load.
  task automatic go(input bit w4, input logic [7:0] s, input bit disturb, input int exp_lat);
    int n;
    @(negedge clk);
    if (w4) begin s4 = s[3:0]; run4 = 1'b1; end
    else    begin s8 = s;      run8 = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_rise", w4 ? busy4 : busy8, 1);
      if (disturb) begin
        s8   = s8 ^ 8'hA5;
        clr8 = (n == 5);
      end
    end while (!(w4 ? done4 : done8) && n < 64);
    clr8 = 1'b0;
    check("latency", n, exp_lat);
    check("busy_fall", w4 ? busy4 : busy8, 0);
  endtask

  task automatic release_run(input bit w4);
    @(negedge clk);
    if (w4) run4 = 1'b0; else run8 = 1'b0;
    @(negedge clk);
    check("done_drop", w4 ? done4 : done8, 0);
  endtask

  initial begin
    rst = 1'b1; run8 = 0; clr8 = 0; s8 = 0; run4 = 0; clr4 = 0; s4 = 0;
    repeat (2) @(negedge clk);
    check("rst_a", a8, 0);
    check("rst_b", b8, 0);
    check("rst_x", x8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    rst = 1'b0;

    // 3 x 7 = 21
    load(0, 8'h03); go(0, 8'h07, 0, 17);
    check("m37_a", a8, 8'h00); check("m37_b", b8, 8'h15); check("m37_x", x8, 0);
    release_run(0);

    // -1 x -1 = 1
    load(0, 8'hFF); go(0, 8'hFF, 0, 17);
    check("mnn_a", a8, 8'h00); check("mnn_b", b8, 8'h01); check("mnn_x", x8, 0);
    release_run(0);

    // -128 x 127 = -16256 = 0xC080
    load(0, 8'h7F); go(0, 8'h80, 0, 17);
    check("mmin_a", a8, 8'hC0); check("mmin_b", b8, 8'h80); check("mmin_x", x8, 1);
    release_run(0);

    // -128 x -128 = 16384 = 0x4000
    load(0, 8'h80); go(0, 8'h80, 0, 17);
    check("mmm_a", a8, 8'h40); check("mmm_b", b8, 8'h00); check("mmm_x", x8, 0);
    release_run(0);

    // Chained: 2 x 3 = 6, then 6 x 3 = 18
    load(0, 8'h02); go(0, 8'h03, 0, 17);
    check("ch1_a", a8, 8'h00); check("ch1_b", b8, 8'h06);
    release_run(0);
    go(0, 8'h03, 0, 17);
    check("ch2_a", a8, 8'h00); check("ch2_b", b8, 8'h12);
    release_run(0);

    // S scrambled and load pulsed mid-run: still 3 x 7
    load(0, 8'h03); go(0, 8'h07, 1, 17);
    check("dist_a", a8, 8'h00); check("dist_b", b8, 8'h15); check("dist_x", x8, 0);
    release_run(0);

    // Load and Run together in IDLE: load wins, no start
    @(negedge clk); s8 = 8'h55; clr8 = 1'b1; run8 = 1'b1;
    @(negedge clk); clr8 = 1'b0; run8 = 1'b0;
    check("prio_busy", busy8, 0);
    check("prio_b", b8, 8'h55);

    // Reset sampled on edge 5 of a 3 x 7 run
    load(0, 8'h03);
    @(negedge clk); s8 = 8'h07; run8 = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_a", a8, 8'h05);
    rst = 1'b1; run8 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_a", a8, 0); check("mid_rst_b", b8, 0); check("mid_rst_x", x8, 0);
    check("mid_rst_busy", busy8, 0); check("mid_rst_done", done8, 0);
    @(negedge clk);
    check("post_rst_idle", busy8, 0);

    // WIDTH=4: -7 x 5 = -35 = 0xDD
    load(1, 8'h09); go(1, 8'h05, 0, 9);
    check("w4_a", a4, 4'hD); check("w4_b", b4, 4'hD); check("w4_x", x4, 1);
    repeat (3) begin
      @(negedge clk);
      check("hold_done", done4, 1);
      check("hold_busy", busy4, 0);
    end
    @(negedge clk); s4 = 4'h3; clr4 = 1'b1;
    @(negedge clk); clr4 = 1'b0;
    check("dl_b", b4, 4'h3); check("dl_a", a4, 4'h0); check("dl_x", x4, 0);
    check("dl_done", done4, 1);
    release_run(1);
    check("w4_idle_busy", busy4, 0);
    go(1, 8'h02, 0, 9);
    check("w4_ch_a", a4, 4'h0); check("w4_ch_b", b4, 4'h6);
    release_run(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
